uart_tx_unit: RTL and testbench

UART transmitter that serialises one byte into a fixed 11-bit frame on data_tx, LSB first: start bit, 8 data bits, parity slot, stop bit. It sits directly upstream of the receiver. Its data_tx output drives the receiver's data_tx input. It shares the receiver's parity_type and baud_rate encodings and its 50 MHz system clock. A single-cycle send strobe loads a byte, and completion is reported with active_flag and done_flag.

---
 rtl/uart_tx_unit.sv | 149 ++++++++++++++
 tb/tb_uart_tx_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, 8 data bits LSB first, parity slot, stop bit.
// Bit period is CLK_HZ/baud clocks, with the baud code latched when send is accepted.
module uart_tx_unit #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic       data_tx,
  output logic       active_flag,
  output logic       done_flag
);

  // Wide enough for the slowest (2400 baud) divisor.
  localparam int unsigned CntW = $clog2(CLK_HZ / 2400 + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        par_q, par_d;
  logic [1:0]        baud_q, baud_d;
  logic              tx_q, tx_d;
  logic              active_q, active_d;
  logic              done_q, done_d;

  logic [CntW-1:0]   div_m1;
  logic              parity_bit;
  logic              bit_end;

  // Last count value of a bit period for the latched baud code.
  always_comb begin
    unique case (baud_q)
      2'b00:   div_m1 = CntW'(CLK_HZ / 2400 - 1);
      2'b01:   div_m1 = CntW'(CLK_HZ / 4800 - 1);
      2'b10:   div_m1 = CntW'(CLK_HZ / 9600 - 1);
      default: div_m1 = CntW'(CLK_HZ / 19200 - 1);
    endcase
  end

  // Parity slot value; "none" codes keep the line high so the frame stays 11 bits.
  always_comb begin
    unique case (par_q)
      2'b01:   parity_bit = ~^data_q;
      2'b10:   parity_bit = ^data_q;
      default: parity_bit = 1'b1;
    endcase
  end

  assign bit_end = (cnt_q == div_m1);

  // Next-state logic: counter, bit index, line value and flags.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_d    = par_q;
    baud_d   = baud_q;
    tx_d     = tx_q;
    active_d = active_q;
    done_d   = 1'b0;

    if (state_q == StIdle) begin
      tx_d     = 1'b1;
      active_d = 1'b0;
      if (send) begin
        data_d   = data_in;
        par_d    = parity_type;
        baud_d   = baud_rate;
        state_d  = StStart;
        tx_d     = 1'b0;
        active_d = 1'b1;
        cnt_d    = '0;
        idx_d    = 3'd0;
      end
    end else if (!bit_end) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      unique case (state_q)
        StStart: begin
          state_d = StData;
          idx_d   = 3'd0;
          tx_d    = data_q[0];
        end
        StData: begin
          if (idx_q == 3'd7) begin
            state_d = StParity;
            tx_d    = parity_bit;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end
        end
        StParity: begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
        StStop: begin
          state_d  = StIdle;
          tx_d     = 1'b1;
          active_d = 1'b0;
          done_d   = 1'b1;
        end
        default: begin
          state_d  = StIdle;
          tx_d     = 1'b1;
          active_d = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset; a reset abandons any frame.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      data_q   <= 8'h00;
      par_q    <= 2'b00;
      baud_q   <= 2'b00;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      baud_q   <= baud_d;
      tx_q     <= tx_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign data_tx     = tx_q;
  assign active_flag = active_q;
  assign done_flag   = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit: frames are compared cycle by cycle against bit lists
// computed from the framing rules, and mid-bit samples are decoded like a receiver.
module tb_uart_tx_unit;

  // Scaled clock keeps frames short; divisors 416/208/104/52 still truncate.
  localparam int unsigned ClkHz = 1000000;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       send;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic       data_tx;
  logic       active_flag;
  logic       done_flag;

  int checks = 0;
  int errors = 0;

  logic [7:0] chain_d;
  logic [1:0] chain_p;
  logic [1:0] chain_b;

  always #5 clock = ~clock;

  uart_tx_unit #(.CLK_HZ(ClkHz)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .send        (send),
    .data_in     (data_in),
    .parity_type (parity_type),
    .baud_rate   (baud_rate),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .done_flag   (done_flag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned div_of(input logic [1:0] b);
    int unsigned baud;
    case (b)
      2'b00:   baud = 2400;
      2'b01:   baud = 4800;
      2'b10:   baud = 9600;
      default: baud = 19200;
    endcase
    return ClkHz / baud;
  endfunction

  // Frame bits in transmit order, index 0 = start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic [1:0] p);
    logic [10:0] f;
    int ones;
    ones = $countones(d);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    if (p == 2'b01)      f[9] = (ones % 2 == 0);
    else if (p == 2'b10) f[9] = (ones % 2 == 1);
    else                 f[9] = 1'b1;
    f[10] = 1'b1;
    return f;
  endfunction

  // Send one frame and check it. preset: send already raised by the previous frame.
  // disturb_at / reset_at: cycle offsets for mid-frame events (-1 = none).
  // chain: raise send for chain_* a few cycles before the end and hold it through done.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b,
                           input bit preset, input int disturb_at, input int reset_at,
                           input bit chain);
    int unsigned dv;
    logic [10:0] f;
    logic [10:0] samp;
    int          bad[11];
    int          act_bad;
    int          done_bad;
    int          quiet;
    int          k;
    int          ones;
    logic [2:0]  rx_err;
    dv = div_of(b);
    f = frame_of(d, p);
    samp = '0;
    act_bad = 0;
    done_bad = 0;
    for (int i = 0; i < 11; i++) bad[i] = 0;
    if (!preset) begin
      data_in = d;
      parity_type = p;
      baud_rate = b;
      send = 1'b1;
    end
    @(negedge clock);
    send = 1'b0;
    // Inputs after accept must not matter.
    data_in = 8'($urandom);
    parity_type = 2'($urandom);
    baud_rate = 2'($urandom);
    for (int c = 0; c < int'(11 * dv); c++) begin
      if (c == reset_at) begin
        reset_n = 1'b0;
        @(negedge clock);
        chk("abort_tx", 32'(data_tx), 1);
        chk("abort_active", 32'(active_flag), 0);
        chk("abort_done", 32'(done_flag), 0);
        reset_n = 1'b1;
        quiet = 0;
        for (int j = 0; j < int'(2 * dv); j++) begin
          @(negedge clock);
          if (active_flag !== 1'b0 || done_flag !== 1'b0 || data_tx !== 1'b1) quiet++;
        end
        chk("abort_quiet", 32'(quiet), 0);
        return;
      end
      k = c / int'(dv);
      if (data_tx !== f[k]) bad[k]++;
      if (active_flag !== 1'b1) act_bad++;
      if (done_flag !== 1'b0) done_bad++;
      if (c % int'(dv) == int'(dv) / 2) samp[k] = data_tx;
      if (c == disturb_at) begin
        send = 1'b1;
        data_in = 8'hFF;
        baud_rate = ~baud_rate;
      end
      if (c == disturb_at + 1) send = 1'b0;
      if (chain && c == int'(11 * dv) - 3) begin
        data_in = chain_d;
        parity_type = chain_p;
        baud_rate = chain_b;
        send = 1'b1;
      end
      @(negedge clock);
    end
    chk("done_pulse", 32'(done_flag), 1);
    chk("end_active", 32'(active_flag), 0);
    chk("end_tx", 32'(data_tx), 1);
    for (int i = 0; i < 11; i++) chk($sformatf("bit%0d_hold", i), 32'(bad[i]), 0);
    chk("active_during", 32'(act_bad), 0);
    chk("done_early", 32'(done_bad), 0);
    // Receiver-style decode of mid-bit samples.
    ones = $countones(samp[9:1]);
    rx_err[2] = (samp[0] !== 1'b0);
    if (p == 2'b01)      rx_err[1] = (ones % 2 != 1);
    else if (p == 2'b10) rx_err[1] = (ones % 2 != 0);
    else                 rx_err[1] = 1'b0;
    rx_err[0] = (samp[10] !== 1'b1);
    chk("rx_data", 32'(samp[8:1]), 32'(d));
    chk("rx_err", 32'(rx_err), 0);
    if (!chain) begin
      quiet = 0;
      for (int j = 0; j < 8; j++) begin
        @(negedge clock);
        if (active_flag !== 1'b0 || done_flag !== 1'b0 || data_tx !== 1'b1) quiet++;
      end
      chk("idle_after", 32'(quiet), 0);
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [1:0] rp;
    logic [1:0] rb;
    reset_n = 1'b0;
    send = 1'b1;
    data_in = 8'h55;
    parity_type = 2'b00;
    baud_rate = 2'b11;
    chain_d = 8'h00;
    chain_p = 2'b00;
    chain_b = 2'b00;
    // Reset wins over a held send.
    repeat (2) begin
      @(negedge clock);
      chk("rst_tx", 32'(data_tx), 1);
      chk("rst_active", 32'(active_flag), 0);
      chk("rst_done", 32'(done_flag), 0);
    end
    reset_n = 1'b1;
    send = 1'b0;
    repeat (5) begin
      @(negedge clock);
      chk("post_rst_idle", 32'(active_flag), 0);
    end

    run_frame(8'h2B, 2'b01, 2'b10, 1'b0, -1, -1, 1'b0);
    run_frame(8'h2B, 2'b10, 2'b11, 1'b0, -1, -1, 1'b0);
    run_frame(8'h00, 2'b00, 2'b11, 1'b0, -1, -1, 1'b0);
    // Mid-frame send with new data and baud is ignored.
    run_frame(8'h2B, 2'b01, 2'b11, 1'b0, 3 * 52 + 7, -1, 1'b0);
    // Back-to-back frames with send held through done.
    chain_d = 8'hA5;
    chain_p = 2'b10;
    chain_b = 2'b11;
    run_frame(8'h3C, 2'b01, 2'b11, 1'b0, -1, -1, 1'b1);
    run_frame(8'hA5, 2'b10, 2'b11, 1'b1, -1, -1, 1'b0);
    // Reset during data bit 4, then a fresh frame.
    run_frame(8'hC3, 2'b10, 2'b10, 1'b0, -1, 5 * 104 + 30, 1'b0);
    run_frame(8'h2B, 2'b01, 2'b10, 1'b0, -1, -1, 1'b0);
    run_frame(8'hA5, 2'b01, 2'b10, 1'b0, -1, -1, 1'b0);
    run_frame(8'hA5, 2'b10, 2'b11, 1'b0, -1, -1, 1'b0);
    run_frame(8'h2B, 2'b10, 2'b11, 1'b0, -1, -1, 1'b0);
    run_frame(8'hFF, 2'b11, 2'b01, 1'b0, -1, -1, 1'b0);

    repeat (8) begin
      rd = 8'($urandom);
      rp = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(0, 3));
      run_frame(rd, rp, rb, 1'b0, -1, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
